sseg_display_driver: RTL and testbench

Multiplexed four-digit seven-segment display driver on the motherboard output side. It consumes the 16-bit value the processor writes to its display port and scans it onto the board's digit-enable lines (`sseg`) and segment lines. It blinks the whole display while the processor is halted. It sits directly downstream of the processor core, fed by its write strobe and `HALT` line.

---
 rtl/display_pkg.sv | 27 ++
 rtl/sseg_display_driver_seg_decoder.sv | 33 +++
 rtl/sseg_display_driver.sv | 164 ++++++++++++++++
 tb/tb_sseg_display_driver.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared constants for the seven-segment display driver: digit count and
// active-low hex segment patterns, bit order {g,f,e,d,c,b,a}.
package display_pkg;

  localparam int unsigned NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef logic [3:0] nibble_t;

endpackage

// File: rtl/sseg_display_driver_seg_decoder.sv
// Purely combinational hex nibble to active-low segment pattern lookup.
module seg_decoder
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Hex lookup table.
  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/sseg_display_driver.sv
// Four-digit multiplexed seven-segment driver. Writes are held pending and
// committed only at frame boundaries (no tearing); the display blinks by
// whole frames while halt is high.
// Optional macro SSEG_LEADING_ZERO_BLANK_EN: blank leading zero digits 3..1.
module sseg_display_driver
  import display_pkg::*;
#(
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned BLINK_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [15:0]           wr_data,
  input  logic [3:0]            dp_in,
  input  logic                  halt,
  output logic                  wr_ack,
  output logic [NUM_DIGITS-1:0] sseg,
  output logic [6:0]            seg,
  output logic                  dp
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam int unsigned FRM_W = BLINK_LOG2 + 1;

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]       dig_q, dig_d;
  logic [FRM_W-1:0] frm_cnt_q, frm_cnt_d;
  logic             blank_q, blank_d;
  logic [15:0]      pend_val_q, pend_val_d;
  logic [3:0]       pend_dp_q, pend_dp_d;
  logic             pend_vld_q, pend_vld_d;
  logic [15:0]      disp_val_q, disp_val_d;
  logic [3:0]       disp_dp_q, disp_dp_d;
  logic             wr_ack_q, wr_ack_d;
  logic [3:0]       sseg_q, sseg_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;

  logic             tick;
  logic             frame_end;
  nibble_t          cur_nib;
  logic [6:0]       dec_seg;
  logic             lz_blank;

  // Scan divider, digit index, frame counter, halt-blank sample, write path.
  always_comb begin
    tick       = (div_cnt_q == DIV_LAST);
    frame_end  = tick && (dig_q == 2'd3);
    div_cnt_d  = tick ? '0 : div_cnt_q + DIV_W'(1);
    dig_d      = tick ? dig_q + 2'd1 : dig_q;
    frm_cnt_d  = frame_end ? frm_cnt_q + FRM_W'(1) : frm_cnt_q;
    blank_d    = frame_end ? (halt & frm_cnt_d[FRM_W-1]) : blank_q;
    pend_val_d = pend_val_q;
    pend_dp_d  = pend_dp_q;
    pend_vld_d = pend_vld_q;
    disp_val_d = disp_val_q;
    disp_dp_d  = disp_dp_q;
    wr_ack_d   = 1'b0;
    if (frame_end && pend_vld_q) begin
      disp_val_d = pend_val_q;
      disp_dp_d  = pend_dp_q;
      pend_vld_d = 1'b0;
      wr_ack_d   = 1'b1;
    end
    // A write in the commit cycle lands after the commit so it stays pending.
    if (wr_en) begin
      pend_val_d = wr_data;
      pend_dp_d  = dp_in;
      pend_vld_d = 1'b1;
    end
  end

  // Nibble mux on the next digit, using the post-commit display value so the
  // ack cycle already shows the new digit 0.
  always_comb begin
    cur_nib = disp_val_d[3:0];
    case (dig_d)
      2'd0: cur_nib = disp_val_d[3:0];
      2'd1: cur_nib = disp_val_d[7:4];
      2'd2: cur_nib = disp_val_d[11:8];
      2'd3: cur_nib = disp_val_d[15:12];
      default: cur_nib = disp_val_d[3:0];
    endcase
  end

  // Leading-zero suppression for digits 3..1.
  always_comb begin
    lz_blank = 1'b0;
`ifdef SSEG_LEADING_ZERO_BLANK_EN
    case (dig_d)
      2'd1: lz_blank = (disp_val_d[15:4]  == '0) && !disp_dp_d[1];
      2'd2: lz_blank = (disp_val_d[15:8]  == '0) && !disp_dp_d[2];
      2'd3: lz_blank = (disp_val_d[15:12] == '0) && !disp_dp_d[3];
      default: lz_blank = 1'b0;
    endcase
`else
    lz_blank = 1'b0;
`endif
  end

  seg_decoder u_seg_decoder (
    .nibble (cur_nib),
    .seg    (dec_seg)
  );

  // Digit outputs refresh only on tick.
  always_comb begin
    sseg_d = sseg_q;
    seg_d  = seg_q;
    dp_d   = dp_q;
    if (tick) begin
      if (blank_d) begin
        sseg_d = '1;
        seg_d  = SEG_BLANK;
        dp_d   = 1'b1;
      end else begin
        sseg_d = ~(4'b0001 << dig_d);
        seg_d  = lz_blank ? SEG_BLANK : dec_seg;
        dp_d   = ~disp_dp_d[dig_d];
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt_q  <= '0;
      dig_q      <= '0;
      frm_cnt_q  <= '0;
      blank_q    <= 1'b0;
      pend_val_q <= '0;
      pend_dp_q  <= '0;
      pend_vld_q <= 1'b0;
      disp_val_q <= '0;
      disp_dp_q  <= '0;
      wr_ack_q   <= 1'b0;
      sseg_q     <= '1;
      seg_q      <= SEG_BLANK;
      dp_q       <= 1'b1;
    end else begin
      div_cnt_q  <= div_cnt_d;
      dig_q      <= dig_d;
      frm_cnt_q  <= frm_cnt_d;
      blank_q    <= blank_d;
      pend_val_q <= pend_val_d;
      pend_dp_q  <= pend_dp_d;
      pend_vld_q <= pend_vld_d;
      disp_val_q <= disp_val_d;
      disp_dp_q  <= disp_dp_d;
      wr_ack_q   <= wr_ack_d;
      sseg_q     <= sseg_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
    end
  end

  assign wr_ack = wr_ack_q;
  assign sseg   = sseg_q;
  assign seg    = seg_q;
  assign dp     = dp_q;

endmodule

// File: tb/tb_sseg_display_driver.sv
// Self-checking bench for sseg_display_driver: vector table, hand sequences
// for frame-boundary corner cases, and random traffic against a time-based
// reference model (tick k happens at edge k*S, digit k%4, frame end at k%4==0).
module tb_sseg_display_driver;

  localparam int S  = 4;
  localparam int BL = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wr_en = 1'b0;
  logic [15:0] wr_data = '0;
  logic [3:0]  dp_in = '0;
  logic        halt = 1'b0;
  logic        wr_ack;
  logic [3:0]  sseg;
  logic [6:0]  seg;
  logic        dp;

  always #5 clk = ~clk;

  sseg_display_driver #(.SCAN_DIV(S), .BLINK_LOG2(BL)) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .dp_in   (dp_in),
    .halt    (halt),
    .wr_ack  (wr_ack),
    .sseg    (sseg),
    .seg     (seg),
    .dp      (dp)
  );

  logic [6:0] segtab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int total = 0;
  int bad   = 0;

  // Reference model state.
  int          n;
  int          m_frames;
  logic [15:0] m_disp, m_pend;
  logic [3:0]  m_ddp, m_pdp;
  bit          m_pvld, m_blank;
  logic        e_ack, e_dp;
  logic [3:0]  e_sseg;
  logic [6:0]  e_seg;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s at t=%0t edge=%0d: got %0h expected %0h", name, $time, n, act, exp_v);
    end
  endtask

  task automatic model_reset();
    n = 0; m_frames = 0; m_disp = '0; m_pend = '0; m_ddp = '0; m_pdp = '0;
    m_pvld = 0; m_blank = 0;
    e_ack = 0; e_sseg = 4'hF; e_seg = 7'h7F; e_dp = 1;
  endtask

  task automatic model_edge(input bit we, input logic [15:0] wd, input logic [3:0] wdp, input bit h);
    int d;
    logic [15:0] hi;
    n++;
    e_ack = 0;
    if (n % S == 0) begin
      d = (n / S) % 4;
      if (d == 0) begin
        if (m_pvld) begin
          m_disp = m_pend; m_ddp = m_pdp; m_pvld = 0; e_ack = 1;
        end
        m_frames++;
        m_blank = h && (((m_frames >> BL) & 1) == 1);
      end
      if (m_blank) begin
        e_sseg = 4'hF; e_seg = 7'h7F; e_dp = 1;
      end else begin
        e_sseg = 4'hF;
        e_sseg[d] = 1'b0;
        hi = m_disp >> (4 * d);
        e_seg = segtab[hi[3:0]];
`ifdef SSEG_LEADING_ZERO_BLANK_EN
        if (d > 0 && hi == 16'h0 && !m_ddp[d]) e_seg = 7'h7F;
`endif
        e_dp = ~m_ddp[d];
      end
    end
    if (we) begin
      m_pend = wd; m_pdp = wdp; m_pvld = 1;
    end
  endtask

  // One clock: drive inputs, step model at the edge, compare 1 time unit later.
  task automatic cyc(input bit we, input logic [15:0] wd, input logic [3:0] wdp);
    wr_en = we; wr_data = wd; dp_in = wdp;
    @(posedge clk);
    model_edge(we, wd, wdp, halt);
    #1;
    check("outputs_vs_model", 32'({wr_ack, sseg, seg, dp}), 32'({e_ack, e_sseg, e_seg, e_dp}));
    wr_en = 1'b0;
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) cyc(0, '0, '0);
  endtask

  task automatic wait_ack(input string name);
    bit got;
    got = 0;
    for (int i = 0; i < 8 * S + 2 && !got; i++) begin
      cyc(0, '0, '0);
      if (wr_ack === 1'b1) got = 1;
    end
    check(name, 32'(got), 32'd1);
  endtask

  task automatic align_frame_start();
    for (int i = 0; i < 4 * S && (n % (4 * S)) != 0; i++) cyc(0, '0, '0);
  endtask

  typedef struct {
    logic [15:0] val;
    logic [3:0]  dpv;
    logic [6:0]  s [4];
  } vec_t;

  vec_t tbl [4];
  int   acks;
  logic [6:0] seg_at_ack;
  logic [7:0] pat;
  int   blanks;
  logic [6:0] lead;

  initial begin
    tbl[0] = '{16'h12AF, 4'b0100, '{7'h0E, 7'h08, 7'h24, 7'h79}};
    tbl[1] = '{16'h8C3E, 4'b0001, '{7'h06, 7'h30, 7'h46, 7'h00}};
    tbl[2] = '{16'hF960, 4'b1000, '{7'h40, 7'h02, 7'h10, 7'h0E}};
    tbl[3] = '{16'h7D4B, 4'b0000, '{7'h03, 7'h19, 7'h21, 7'h78}};
    model_reset();

    // Reset state.
    repeat (10) @(posedge clk);
    #1;
    check("reset_outputs", 32'({wr_ack, sseg, seg, dp}), 32'({1'b0, 4'hF, 7'h7F, 1'b1}));
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    run(3);
    check("before_first_tick", 32'(sseg), 32'(4'hF));
    run(1);
    check("first_digit_is_1", 32'(sseg), 32'(4'b1101));

    // Table of writes: each digit checked over the frame after the ack.
    foreach (tbl[v]) begin
      run($urandom_range(0, 7));
      cyc(1, tbl[v].val, tbl[v].dpv);
      wait_ack("table_ack_seen");
      for (int d = 0; d < 4; d++) begin
        if (d > 0) run(S);
        check("table_digit", 32'({sseg, seg, dp}),
              32'({~(4'b0001 << d), tbl[v].s[d], ~tbl[v].dpv[d]}));
      end
    end

    // Back-to-back writes in one frame: one ack, last value shown.
    align_frame_start();
    cyc(1, 16'h1111, 4'h0);
    run(2);
    cyc(1, 16'h2222, 4'h0);
    acks = 0; seg_at_ack = '0;
    for (int i = 0; i < 8 * S; i++) begin
      cyc(0, '0, '0);
      if (wr_ack === 1'b1) begin acks++; seg_at_ack = seg; end
    end
    check("b2b_ack_count", 32'(acks), 32'd1);
    check("b2b_shows_2222", 32'(seg_at_ack), 32'(7'h24));

    // Write coincident with frame boundary while 3333 pending.
    cyc(1, 16'h3333, 4'h0);
    for (int i = 0; i < 4 * S && ((n + 1) % (4 * S)) != 0; i++) cyc(0, '0, '0);
    cyc(1, 16'h4444, 4'h0);
    check("coinc_ack_3333", 32'({wr_ack, seg}), 32'({1'b1, 7'h30}));
    acks = 0;
    for (int i = 0; i < 4 * S - 1; i++) begin
      cyc(0, '0, '0);
      if (wr_ack === 1'b1) acks++;
    end
    check("coinc_no_early_ack", 32'(acks), 32'd0);
    cyc(0, '0, '0);
    check("coinc_ack_4444", 32'({wr_ack, seg}), 32'({1'b1, 7'h19}));

    // Halt blink: two frames lit, two blank.
    halt = 1'b1;
    align_frame_start();
    pat = '0;
    for (int f = 0; f < 8; f++) begin
      run(4 * S);
      pat[f] = (sseg == 4'hF) && (seg == 7'h7F);
    end
    check("blink_pattern", 32'((pat == 8'h33) || (pat == 8'h66) || (pat == 8'hCC) || (pat == 8'h99)), 32'd1);
    halt = 1'b0;
    blanks = 0;
    for (int f = 0; f < 8; f++) begin
      run(4 * S);
      if (sseg == 4'hF) blanks++;
    end
    check("no_blink_when_running", 32'(blanks), 32'd0);

    // Leading zeros: blanked only when the macro is defined.
`ifdef SSEG_LEADING_ZERO_BLANK_EN
    lead = 7'h7F;
`else
    lead = 7'h40;
`endif
    cyc(1, 16'h0005, 4'h0);
    wait_ack("lz_ack_seen");
    check("lz_digit0", 32'({sseg, seg}), 32'({4'b1110, 7'h12}));
    for (int d = 1; d < 4; d++) begin
      run(S);
      check("lz_digit_upper", 32'({sseg, seg}), 32'({~(4'b0001 << d), lead}));
    end

    // Random traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 199) == 0) halt = ~halt;
      cyc($urandom_range(0, 15) == 0, 16'($urandom), 4'($urandom));
    end
    halt = 1'b0;
    run(8 * S);

    // Reset mid-frame with a write pending: discarded, never acked.
    align_frame_start();
    cyc(1, 16'hABCD, 4'hF);
    run(3);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_outputs", 32'({wr_ack, sseg, seg, dp}), 32'({1'b0, 4'hF, 7'h7F, 1'b1}));
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    acks = 0;
    for (int i = 0; i < 8 * S; i++) begin
      cyc(0, '0, '0);
      if (wr_ack === 1'b1) acks++;
      if (i == 4 * S - 1)
        check("post_reset_digit0_zero", 32'({sseg, seg, dp}), 32'({4'b1110, 7'h40, 1'b1}));
    end
    check("post_reset_no_ack", 32'(acks), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
